// File: rtl/tt_pin_pkg.sv
// Shared types and constants for the pad-side byte transmitter.
package tt_pin_pkg;

  localparam int BYTE_W = 8;
  localparam int TX_W   = BYTE_W + 1;

  localparam logic [BYTE_W-1:0] OE_DRIVE   = 8'hFF;
  localparam logic [BYTE_W-1:0] OE_RELEASE = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WAIT_HI,
    WAIT_LO
  } state_t;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } tx_word_t;

endpackage

// File: rtl/tt_byte_fifo.sv
// Small synchronous FIFO of tx_word_t entries with an occupancy count.
module tt_byte_fifo
  import tt_pin_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [TX_W-1:0]          wr_word,
  input  logic                     pop,
  output logic [TX_W-1:0]          rd_word,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  tx_word_t          mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;
  logic              do_push;
  logic              do_pop;

  // Pointers wrap naturally because DEPTH is a power of two.
  assign do_push = push && (cnt != CNT_FULL);
  assign do_pop  = pop && (cnt != '0);
  assign rd_word = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= tx_word_t'(wr_word);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/tt_pin_byte_tx.sv
// Byte transmitter to the TinyTapeout pads: FIFO-buffered bytes are sent to an
// external host with a 4-phase strobe/ack handshake on uio_out.
module tt_pin_byte_tx
  import tt_pin_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic [7:0] pin_data,
  output logic [7:0] pin_oe,
  output logic       pin_strobe,
  output logic       pin_last,
  input  logic       pin_ack,
  output logic       busy,
  output logic       err,
  input  logic       err_clr
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SU_W  = $clog2(SETUP_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [SU_W-1:0]  SU_LAST  = SU_W'(SETUP_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  state_t                 state;
  tx_word_t               tx_word;
  tx_word_t               head_word;
  logic [SU_W-1:0]        setup_cnt;
  logic [TO_W-1:0]        to_cnt;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic [CNT_W-1:0]       fifo_count;
  logic [TX_W-1:0]        fifo_head;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic                   fifo_push;

  // s_valid/s_ready: a byte transfers on every edge where both are high;
  // s_ready depends only on the registered FIFO count, never on s_valid.
  assign s_ready    = (fifo_count != CNT_FULL);
  assign fifo_push  = s_valid && s_ready;
  assign fifo_empty = (fifo_count == '0);
  assign head_word  = tx_word_t'(fifo_head);

  // A new byte is loaded from IDLE, or straight from WAIT_LO once the host
  // has released ack, so oe stays driven across back-to-back bytes.
  assign fifo_pop = ena && !fifo_empty &&
                    ((state == IDLE) || ((state == WAIT_LO) && !ack_s));

  assign pin_data = tx_word.data;
  assign pin_last = tx_word.last;
  assign busy     = (state != IDLE) || !fifo_empty;
  assign ack_s    = ack_sync[SYNC_STAGES-1];

  tt_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .wr_word ({s_last, s_data}),
    .pop     (fifo_pop),
    .rd_word (fifo_head),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], pin_ack};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx_word    <= '0;
      setup_cnt  <= '0;
      to_cnt     <= '0;
      pin_oe     <= OE_RELEASE;
      pin_strobe <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_pop) begin
            tx_word   <= head_word;
            pin_oe    <= OE_DRIVE;
            setup_cnt <= '0;
            to_cnt    <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (setup_cnt == SU_LAST) begin
            pin_strobe <= 1'b1;
            to_cnt     <= '0;
            state      <= WAIT_HI;
          end else begin
            setup_cnt <= setup_cnt + 1'b1;
          end
        end
        WAIT_HI: begin
          if (ack_s) begin
            pin_strobe <= 1'b0;
            to_cnt     <= '0;
            state      <= WAIT_LO;
          end else if (to_cnt == TO_LAST) begin
            err        <= 1'b1;
            pin_strobe <= 1'b0;
            pin_oe     <= OE_RELEASE;
            tx_word    <= '0;
            state      <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WAIT_LO: begin
          if (!ack_s) begin
            if (fifo_pop) begin
              tx_word   <= head_word;
              setup_cnt <= '0;
              to_cnt    <= '0;
              state     <= SETUP;
            end else begin
              pin_oe  <= OE_RELEASE;
              tx_word <= '0;
              state   <= IDLE;
            end
          end else if (to_cnt == TO_LAST) begin
            err     <= 1'b1;
            pin_oe  <= OE_RELEASE;
            tx_word <= '0;
            state   <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // Later assignment wins: a clear beats a timeout set in the same cycle.
      if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tt_pin_byte_tx.sv
// Self-checking bench for tt_pin_byte_tx: vector table, scoreboard queue and
// hand-written multi-cycle sequences with a behavioural host.
module tb_tt_pin_byte_tx;

  localparam int FIFO_DEPTH     = 4;
  localparam int SETUP_CYCLES   = 2;
  localparam int TIMEOUT_CYCLES = 255;
  localparam int SYNC_STAGES    = 2;

  localparam int H_NORMAL = 0;
  localparam int H_MUTE   = 1;
  localparam int H_FORCE  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0;
  logic       pin_ack = 1'b0;
  logic       err_clr = 1'b0;
  logic       s_ready;
  logic [7:0] pin_data;
  logic [7:0] pin_oe;
  logic       pin_strobe;
  logic       pin_last;
  logic       busy;
  logic       err;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         ack_dly;
    logic [7:0] exp_data;
    logic       exp_last;
  } vec_t;

  vec_t       vecs [6];
  logic [8:0] exp_q [$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         rise_cnt = 0;
  int         host_mode = H_NORMAL;
  int         ack_dly = 3;
  int         wait_cnt = 0;
  logic       prev_strobe = 1'b0;
  logic [8:0] held_word = '0;

  tt_pin_byte_tx #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .SETUP_CYCLES   (SETUP_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .pin_data   (pin_data),
    .pin_oe     (pin_oe),
    .pin_strobe (pin_strobe),
    .pin_last   (pin_last),
    .pin_ack    (pin_ack),
    .busy       (busy),
    .err        (err),
    .err_clr    (err_clr)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Driver: called and returns at posedge+1; the byte is pushed at the edge in between.
  task automatic push_byte(input logic [7:0] d, input logic l, input logic [8:0] exp_w,
                           input logic expect_out);
    int g = 0;
    while (!s_ready && g < 2000) begin
      step(1);
      g++;
    end
    check("push_ready_wait", s_ready, 1);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    if (expect_out) exp_q.push_back(exp_w);
    step(1);
    s_valid = 1'b0;
  endtask

  task automatic wait_strobe(input string name);
    int g = 0;
    while (!pin_strobe && g < 100) begin
      step(1);
      g++;
    end
    check(name, pin_strobe, 1);
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    while (busy && g < 1000) begin
      step(1);
      g++;
    end
    check(name, busy, 0);
  endtask

  // Behavioural host: acks ack_dly cycles after seeing strobe, drops ack after strobe falls.
  initial begin
    forever begin
      @(negedge clk);
      case (host_mode)
        H_FORCE: pin_ack = 1'b1;
        H_MUTE:  pin_ack = 1'b0;
        default: begin
          if (!pin_strobe) wait_cnt = 0;
          if (!pin_ack && pin_strobe) begin
            if (wait_cnt >= ack_dly) pin_ack = 1'b1;
            else wait_cnt++;
          end else if (pin_ack && !pin_strobe) begin
            pin_ack = 1'b0;
          end
        end
      endcase
    end
  end

  // Scoreboard monitor: each strobe rise must present the next expected byte.
  initial begin
    logic [8:0] exp_w;
    forever begin
      @(negedge clk);
      if (pin_strobe && !prev_strobe) begin
        rise_cnt++;
        held_word = {pin_last, pin_data};
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got %0h expected none at %0t", held_word, $time);
        end else begin
          exp_w = exp_q.pop_front();
          check("sb_byte", {23'd0, held_word}, {23'd0, exp_w});
          check("sb_oe_at_strobe", {24'd0, pin_oe}, 32'h0000_00FF);
        end
      end else if (pin_strobe) begin
        check("sb_data_stable", {23'd0, pin_last, pin_data}, {23'd0, held_word});
      end
      prev_strobe = pin_strobe;
    end
  end

  initial begin
    int   base;
    int   n;
    logic flag;

    vecs[0] = '{8'h00, 1'b0, 0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 1'b1, 1, 8'hFF, 1'b1};
    vecs[2] = '{8'h55, 1'b0, 2, 8'h55, 1'b0};
    vecs[3] = '{8'hAA, 1'b1, 5, 8'hAA, 1'b1};
    vecs[4] = '{8'h80, 1'b0, 3, 8'h80, 1'b0};
    vecs[5] = '{8'h01, 1'b1, 0, 8'h01, 1'b1};

    ena = 1'b1;
    step(3);
    check("rst_s_ready", s_ready, 1);
    check("rst_oe", pin_oe, 0);
    check("rst_data", pin_data, 0);
    check("rst_strobe", pin_strobe, 0);
    check("rst_last", pin_last, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);

    // Single byte with latency checks
    host_mode = H_NORMAL;
    ack_dly = 3;
    push_byte(8'hA5, 1'b1, 9'h1A5, 1'b1);
    check("single_oe_k", pin_oe, 8'h00);
    check("single_busy_k", busy, 1);
    step(1);
    check("single_oe_k1", pin_oe, 8'hFF);
    check("single_data_k1", pin_data, 8'hA5);
    check("single_last_k1", pin_last, 1);
    check("single_strobe_k1", pin_strobe, 0);
    step(1);
    check("single_strobe_k2", pin_strobe, 0);
    step(1);
    check("single_strobe_k3", pin_strobe, 1);
    wait_idle("single_idle");
    check("single_oe_release", pin_oe, 8'h00);
    check("single_data_release", pin_data, 8'h00);
    check("single_strobe_release", pin_strobe, 0);

    // Vector table
    foreach (vecs[i]) begin
      ack_dly = vecs[i].ack_dly;
      push_byte(vecs[i].data, vecs[i].last, {vecs[i].exp_last, vecs[i].exp_data}, 1'b1);
      step(1);
      check("tbl_oe", pin_oe, 8'hFF);
      check("tbl_data", pin_data, vecs[i].exp_data);
      check("tbl_last", pin_last, vecs[i].exp_last);
      step(SETUP_CYCLES);
      check("tbl_strobe", pin_strobe, 1);
      wait_idle("tbl_idle");
      check("tbl_oe_release", pin_oe, 8'h00);
    end

    // Burst of five bytes into a depth-4 FIFO
    ack_dly = 1;
    base = rise_cnt;
    for (int i = 1; i <= 5; i++) begin
      push_byte(8'(i), (i == 5), {(i == 5), 8'(i)}, 1'b1);
    end
    check("burst_full", s_ready, 0);
    flag = 1'b0;
    n = 0;
    while (rise_cnt < base + 5 && n < 1000) begin
      if (pin_oe != 8'hFF) flag = 1'b1;
      step(1);
      n++;
    end
    check("burst_oe_held", flag, 0);
    wait_idle("burst_idle");
    check("burst_count", rise_cnt, base + 5);

    // ena dropped mid-byte
    ack_dly = 4;
    base = rise_cnt;
    push_byte(8'h11, 1'b0, 9'h011, 1'b1);
    wait_strobe("ena_strobe");
    ena = 1'b0;
    push_byte(8'h22, 1'b0, 9'h022, 1'b1);
    push_byte(8'h33, 1'b1, 9'h133, 1'b1);
    n = 0;
    while (pin_oe != 8'h00 && n < 100) begin
      step(1);
      n++;
    end
    check("ena_release", pin_oe, 8'h00);
    check("ena_one_sent", rise_cnt, base + 1);
    check("ena_busy", busy, 1);
    flag = 1'b0;
    repeat (10) begin
      step(1);
      if (pin_oe != 8'h00 || pin_strobe) flag = 1'b1;
    end
    check("ena_no_start", flag, 0);
    ena = 1'b1;
    wait_idle("ena_idle");
    check("ena_all_sent", rise_cnt, base + 3);

    // Timeout in WAIT_HI, next byte still sent
    host_mode = H_MUTE;
    push_byte(8'h3C, 1'b0, 9'h03C, 1'b1);
    push_byte(8'hC3, 1'b1, 9'h1C3, 1'b1);
    wait_strobe("to_strobe");
    n = 0;
    while (!err && n < 400) begin
      step(1);
      n++;
    end
    check("to_len", n, TIMEOUT_CYCLES);
    check("to_oe", pin_oe, 8'h00);
    check("to_strobe_low", pin_strobe, 0);
    check("to_data", pin_data, 8'h00);
    host_mode = H_NORMAL;
    ack_dly = 2;
    wait_idle("to_idle");
    check("to_err_sticky", err, 1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("to_err_clr", err, 0);

    // Ack held high through SETUP
    host_mode = H_FORCE;
    step(4);
    push_byte(8'h5A, 1'b1, 9'h15A, 1'b1);
    wait_strobe("glitch_strobe");
    check("glitch_oe_hi", pin_oe, 8'hFF);
    step(1);
    check("glitch_pass_through", pin_strobe, 0);
    check("glitch_oe_lo", pin_oe, 8'hFF);
    host_mode = H_NORMAL;
    wait_idle("glitch_idle");
    check("glitch_release", pin_oe, 8'h00);

    // Asynchronous reset mid-WAIT_HI with a byte queued
    host_mode = H_MUTE;
    base = rise_cnt;
    push_byte(8'h7E, 1'b0, 9'h07E, 1'b1);
    push_byte(8'hE7, 1'b1, 9'h1E7, 1'b0);
    wait_strobe("arst_strobe");
    step(3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_strobe_low", pin_strobe, 0);
    check("arst_oe", pin_oe, 8'h00);
    check("arst_data", pin_data, 8'h00);
    check("arst_last", pin_last, 0);
    check("arst_s_ready", s_ready, 1);
    check("arst_busy", busy, 0);
    check("arst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    host_mode = H_NORMAL;
    step(20);
    check("arst_queue_lost", rise_cnt, base + 1);
    check("arst_idle_oe", pin_oe, 8'h00);

    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
